// File: rtl/pcs_rx_pkg.sv
// pcs_rx_pkg: shared types, sync-header constants and header validity check
// for the 10GBASE-R receive block synchronizer.
package pcs_rx_pkg;

  typedef enum logic [1:0] {S_TEST, S_SLIP, S_WAIT} lock_state_t;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/pcs_rx_sh_counter.sv
// pcs_rx_sh_counter: test-window block counter and invalid-header counter;
// flags report that the pending increment completes the window / hits the limit.
module pcs_rx_sh_counter #(
  parameter int SH_CNT_MAX = 64,
  parameter int INVLD_MAX  = 16
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_inc_sh,
  input  logic       i_inc_invld,
  output logic [4:0] o_invld_cnt,
  output logic       o_window_done,
  output logic       o_invld_limit
);

  logic [6:0] r_sh_cnt;
  logic [4:0] r_invld_cnt;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_cnt    <= '0;
      r_invld_cnt <= '0;
    end else if (i_clear) begin
      r_sh_cnt    <= '0;
      r_invld_cnt <= '0;
    end else begin
      r_sh_cnt    <= r_sh_cnt + 7'(i_inc_sh);
      r_invld_cnt <= r_invld_cnt + 5'(i_inc_invld);
    end
  end

  assign o_invld_cnt   = r_invld_cnt;
  assign o_window_done = i_inc_sh && (r_sh_cnt == 7'(SH_CNT_MAX - 1));
  assign o_invld_limit = i_inc_invld && (r_invld_cnt == 5'(INVLD_MAX - 1));

endmodule

// File: rtl/pcs_rx_block_lock.sv
// pcs_rx_block_lock: 64b/66b sync-header block lock with gearbox slip requests and
// a 1-cycle header/payload split; PCS_RX_SLIP_CNT_EN adds a saturating slip_count.
module pcs_rx_block_lock
  import pcs_rx_pkg::*;
#(
  parameter int SH_CNT_MAX = 64,
  parameter int INVLD_MAX  = 16,
  parameter int SLIP_WAIT  = 8
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [65:0] rx_data_in,
  input  logic        rx_valid_in,
  output logic [63:0] rx_data_out,
  output logic [1:0]  rx_header,
  output logic        rx_valid_out,
  output logic        block_lock,
  output logic        slip
`ifdef PCS_RX_SLIP_CNT_EN
  ,
  output logic [15:0] slip_count
`endif
);

  lock_state_t r_state, w_next;
  logic [7:0]  r_wait_cnt;
  logic        r_lock;
  logic [4:0]  w_invld_cnt;
  logic        w_hdr_ok, w_test, w_wait_done, w_window_done, w_invld_limit;
  logic        w_inc_sh, w_inc_invld, w_slip_go, w_win_end, w_clear;

  assign w_hdr_ok    = sh_is_valid(rx_data_in[1:0]);
  assign w_test      = (r_state == S_TEST) && rx_valid_in;
  assign w_wait_done = (r_state == S_WAIT) && rx_valid_in && (r_wait_cnt == 8'(SLIP_WAIT - 1));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= S_TEST;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = w_slip_go ? S_SLIP :
             (r_state == S_SLIP) ? S_WAIT :
             (r_state == S_WAIT && !w_wait_done) ? S_WAIT : S_TEST;
  end

  // Unlocked, one bad header slips at once; locked, bad headers are tallied.
  always_comb begin
    w_inc_sh    = w_test && (w_hdr_ok || r_lock);
    w_inc_invld = w_test && !w_hdr_ok && r_lock;
    w_slip_go   = w_test && !w_hdr_ok && (!r_lock || w_invld_limit);
    w_win_end   = w_window_done && !w_slip_go;
    w_clear     = (r_state == S_SLIP) || w_wait_done || w_win_end;
    slip        = (r_state == S_SLIP);
  end

  pcs_rx_sh_counter #(
    .SH_CNT_MAX(SH_CNT_MAX),
    .INVLD_MAX (INVLD_MAX)
  ) u_cnt (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .i_clear      (w_clear),
    .i_inc_sh     (w_inc_sh),
    .i_inc_invld  (w_inc_invld),
    .o_invld_cnt  (w_invld_cnt),
    .o_window_done(w_window_done),
    .o_invld_limit(w_invld_limit)
  );

  // Lock falls on entry to the slip so slip and !block_lock appear together.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_lock     <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_lock     <= (w_slip_go || r_state == S_SLIP) ? 1'b0 :
                    r_lock | (w_win_end && w_hdr_ok && w_invld_cnt == '0);
      r_wait_cnt <= (r_state == S_SLIP || w_wait_done) ? 8'd0 :
                    r_wait_cnt + 8'((r_state == S_WAIT) && rx_valid_in);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_out  <= '0;
      rx_header    <= '0;
      rx_valid_out <= 1'b0;
    end else begin
      rx_data_out  <= rx_data_in[65:2];
      rx_header    <= rx_data_in[1:0];
      rx_valid_out <= rx_valid_in;
    end
  end

  assign block_lock = r_lock;

`ifdef PCS_RX_SLIP_CNT_EN
  logic [15:0] r_slip_count;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_slip_count <= '0;
    else        r_slip_count <= r_slip_count + 16'(slip && r_slip_count != 16'hFFFF);
  end

  assign slip_count = r_slip_count;
`endif

endmodule
